// File: rtl/ham_pkg.sv
// Shared types and constants for the Hamming (7,4) receive path.
package ham_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;

    typedef logic [CW_W-1:0] ham_cw_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } ham_rx_state_t;

endpackage

// File: rtl/ham_word_fifo.sv
// Two-entry codeword FIFO with a registered head; push and pop may coincide even when full.
module ham_word_fifo
    import ham_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  ham_cw_t push_data,
    input  logic    pop,
    output ham_cw_t head,
    output logic    full,
    output logic    empty
);

    logic [1:0] count;
    ham_cw_t    tail;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= push_data;
                    end else if (count == 2'd1) begin
                        tail <= push_data;
                    end
                    if (count != 2'd2) begin
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= push_data;
                    end else begin
                        head <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ham_word_receiver.sv
// Serial codeword receiver: 2-FF synchronizer, frame FSM, 2-entry FIFO, optional output bit flip.
// Define HAM_ERR_INJECT_EN to build in the error-injection stage on word_o.
//
// state     | meaning
// IDLE      | line idle, waiting for rx low
// START     | timing to mid start bit, rejecting glitches
// DATA      | sampling 7 data bits mid-bit, LSB first
// STOP      | sampling the stop bit, pushing or flagging
// WAIT_HIGH | after a framing error, waiting for the line to return high
module ham_word_receiver
    import ham_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_i,
    input  logic            inj_en_i,
    input  logic [2:0]      inj_pos_i,
    output logic [CW_W-1:0] word_o,
    output logic            word_valid_o,
    input  logic            word_ready_i,
    output logic            frame_err_o,
    output logic            overrun_o,
    output logic            busy_o
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LD = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_sync;
    ham_rx_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    ham_cw_t          shift_q;
    ham_cw_t          fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             stop_tick;
    logic             push;
    logic             pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    assign stop_tick    = (state == STOP) && (cnt == '0);
    assign pop          = word_valid_o && word_ready_i;
    assign push         = stop_tick && rx_sync && (!fifo_full || pop);
    assign word_valid_o = !fifo_empty;
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= 3'd0;
            shift_q     <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state   <= START;
                        cnt     <= HALF_LD;
                        bit_cnt <= 3'd0;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rx_sync) begin
                            state <= DATA;
                            cnt   <= FULL_LD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shift_q[bit_cnt] <= rx_sync;
                        cnt              <= FULL_LD;
                        if (bit_cnt == 3'd6) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
                        if (rx_sync) begin
                            state     <= IDLE;
                            overrun_o <= fifo_full && !pop;
                        end else begin
                            state       <= WAIT_HIGH;
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ham_word_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef HAM_ERR_INJECT_EN
    ham_cw_t inj_mask;

    always_comb begin
        inj_mask = '0;
        if (inj_en_i && (inj_pos_i < 3'd7)) begin
            inj_mask[inj_pos_i] = 1'b1;
        end
    end

    assign word_o = fifo_head ^ inj_mask;
`else
    logic unused_inj;
    assign unused_inj = ^{inj_en_i, inj_pos_i};
    assign word_o     = fifo_head;
`endif

endmodule

// File: tb/tb_ham_word_receiver.sv
// Scoreboard bench for ham_word_receiver at CLKS_PER_BIT = 4; follows HAM_ERR_INJECT_EN if defined.
module tb_ham_word_receiver;
    import ham_pkg::*;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic       inj_en_i;
    logic [2:0] inj_pos_i;
    logic [6:0] word_o;
    logic       word_valid_o;
    logic       word_ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int val_cnt  = 0;
    int fe0, ov0, val0;

    ham_cw_t exp_q[$];
    ham_cw_t exp_w;

    ham_word_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .inj_en_i     (inj_en_i),
        .inj_pos_i    (inj_pos_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ham_cw_t model_mask(input logic en, input logic [2:0] pos);
`ifdef HAM_ERR_INJECT_EN
        if (en && pos != 3'd7) return ham_cw_t'(7'd1 << pos);
        return '0;
`else
        return '0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err_o)  fe_cnt++;
            if (overrun_o)    ov_cnt++;
            if (word_valid_o) val_cnt++;
            if (word_valid_o && word_ready_i) begin
                chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    chk("word", 32'(word_o), 32'(exp_w));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx_i = b;
        idle(n);
    endtask

    task automatic send_frame(input ham_cw_t d, input logic stop_b, input logic expect_push);
        ham_cw_t dv;
        dv = d;
        if (expect_push) exp_q.push_back(dv ^ model_mask(inj_en_i, inj_pos_i));
        drive_bit(1'b0, C);
        for (int i = 0; i < 7; i++) drive_bit(dv[i], C);
        drive_bit(stop_b, C);
    endtask

    task automatic snap();
        fe0  = fe_cnt;
        ov0  = ov_cnt;
        val0 = val_cnt;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        rx_i         = 1'b1;
        inj_en_i     = 1'b0;
        inj_pos_i    = 3'd0;
        word_ready_i = 1'b0;
        idle(3);
        chk("rst_word",  32'(word_o), 32'd0);
        chk("rst_valid", 32'(word_valid_o), 32'd0);
        chk("rst_ferr",  32'(frame_err_o), 32'd0);
        chk("rst_ovr",   32'(overrun_o), 32'd0);
        chk("rst_busy",  32'(busy_o), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single good frame, ready held high: one valid cycle, no flags.
        word_ready_i = 1'b1;
        snap();
        send_frame(7'b1100110, 1'b1, 1'b1);
        idle(3 * C);
        chk("t1_valid_cycles", 32'(val_cnt - val0), 32'd1);
        chk("t1_ferr", 32'(fe_cnt - fe0), 32'd0);
        chk("t1_ovr",  32'(ov_cnt - ov0), 32'd0);
        chk("t1_sb",   32'(exp_q.size()), 32'd0);

        // Injection inputs: flip bit 4 in the macro build, ignored otherwise; pos 7 never flips.
        inj_en_i  = 1'b1;
        inj_pos_i = 3'd4;
        send_frame(7'b1100110, 1'b1, 1'b1);
        idle(3 * C);
        inj_pos_i = 3'd7;
        send_frame(7'b1100110, 1'b1, 1'b1);
        idle(3 * C);
        inj_en_i  = 1'b0;
        inj_pos_i = 3'd0;
        chk("t2_sb", 32'(exp_q.size()), 32'd0);

        // Framing error, then line held low, then a good frame.
        snap();
        send_frame(7'b0000001, 1'b0, 1'b0);
        idle(3 * C);
        chk("t3_ferr",  32'(fe_cnt - fe0), 32'd1);
        chk("t3_busy",  32'(busy_o), 32'd1);
        chk("t3_valid", 32'(val_cnt - val0), 32'd0);
        rx_i = 1'b1;
        idle(2 * C);
        chk("t3_idle", 32'(busy_o), 32'd0);
        send_frame(7'b1010101, 1'b1, 1'b1);
        idle(3 * C);
        chk("t3_ferr_once", 32'(fe_cnt - fe0), 32'd1);
        chk("t3_sb", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames with ready low: two buffered, third overruns.
        word_ready_i = 1'b0;
        snap();
        send_frame(7'h11, 1'b1, 1'b1);
        send_frame(7'h22, 1'b1, 1'b1);
        send_frame(7'h33, 1'b1, 1'b0);
        idle(2 * C);
        chk("t4_ovr",   32'(ov_cnt - ov0), 32'd1);
        chk("t4_ferr",  32'(fe_cnt - fe0), 32'd0);
        chk("t4_valid", 32'(word_valid_o), 32'd1);
        chk("t4_head",  32'(word_o), 32'h11);
        word_ready_i = 1'b1;
        wait_drain();
        idle(2);
        chk("t4_empty", 32'(word_valid_o), 32'd0);

        // Start glitch of half a bit: sampled high mid-start, so no frame.
        snap();
        rx_i = 1'b0;
        idle(C / 2);
        rx_i = 1'b1;
        idle(2);
        chk("t5_busy_start", 32'(busy_o), 32'd1);
        idle(3 * C);
        chk("t5_busy_end", 32'(busy_o), 32'd0);
        chk("t5_valid", 32'(val_cnt - val0), 32'd0);
        chk("t5_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

        // Reset in the middle of data bit 3, then a clean frame.
        snap();
        drive_bit(1'b0, C);
        drive_bit(1'b1, C);
        drive_bit(1'b1, C);
        drive_bit(1'b0, C);
        drive_bit(1'b0, C / 2);
        chk("t6_busy_pre", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        rx_i  = 1'b1;
        idle(2);
        chk("t6_rst_busy",  32'(busy_o), 32'd0);
        chk("t6_rst_valid", 32'(word_valid_o), 32'd0);
        rst_n = 1'b1;
        idle(2 * C);
        send_frame(7'b0110011, 1'b1, 1'b1);
        idle(3 * C);
        chk("t6_valid_cycles", 32'(val_cnt - val0), 32'd1);
        chk("t6_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
        chk("t6_sb", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
